// File: rtl/counter_cmd_scheduler.sv
// Round-robin scheduler that lends one 4-bit mode counter to two command requesters,
// drives enable_/mode_/D_ for each accepted run and posts a one-cycle completion record.
module counter_cmd_scheduler #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_mode,
    input  logic [3:0]       req0_data,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req0_stop,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_mode,
    input  logic [3:0]       req1_data,
    input  logic [LEN_W-1:0] req1_len,
    input  logic             req1_stop,

    output logic             enable_,
    output logic [1:0]       mode_,
    output logic [3:0]       D_,
    input  logic             rco_,

    output logic             done_valid,
    output logic             done_id,
    output logic [LEN_W-1:0] done_cycles,
    output logic [LEN_W-1:0] done_rco_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             rr_ptr;
    logic             id_q;
    logic             stop_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cycles;
    logic [LEN_W-1:0] rco_cnt;

    logic             grant_any;
    logic             grant_id;
    logic [1:0]       sel_mode;
    logic [3:0]       sel_data;
    logic [LEN_W-1:0] sel_len;
    logic             sel_stop;
    logic [LEN_W-1:0] cycles_nxt;
    logic [LEN_W-1:0] rco_cnt_nxt;
    logic             run_exit;

    // When both requesters wait, the round-robin pointer breaks the tie.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        sel_mode  = grant_id ? req1_mode : req0_mode;
        sel_data  = grant_id ? req1_data : req0_data;
        sel_len   = grant_id ? req1_len  : req0_len;
        sel_stop  = grant_id ? req1_stop : req0_stop;
    end

    // NOTE: ready is combinational from the registered state, so it is also gated by
    // reset; otherwise a requester could see a handshake while reset is still held.
    assign req0_ready = reset && (state == IDLE) && grant_any && !grant_id;
    assign req1_ready = reset && (state == IDLE) && grant_any &&  grant_id;
    assign busy       = (state == RUN) || (state == DONE);

    // cycles never wraps: exit fires at len_q, which is at most all-ones.
    always_comb begin
        cycles_nxt  = cycles + LEN_W'(1);
        rco_cnt_nxt = (rco_ && (rco_cnt != {LEN_W{1'b1}})) ? rco_cnt + LEN_W'(1) : rco_cnt;
        run_exit    = (cycles_nxt == len_q) || (stop_q && rco_);
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            id_q         <= 1'b0;
            stop_q       <= 1'b0;
            len_q        <= '0;
            cycles       <= '0;
            rco_cnt      <= '0;
            enable_      <= 1'b0;
            mode_        <= '0;
            D_           <= '0;
            done_valid   <= 1'b0;
            done_id      <= 1'b0;
            done_cycles  <= '0;
            done_rco_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mode_   <= sel_mode;
                        D_      <= sel_data;
                        len_q   <= sel_len;
                        stop_q  <= sel_stop;
                        id_q    <= grant_id;
                        rr_ptr  <= ~grant_id;
                        cycles  <= '0;
                        rco_cnt <= '0;
                        if (sel_len == '0) begin
                            state        <= DONE;
                            done_valid   <= 1'b1;
                            done_id      <= grant_id;
                            done_cycles  <= '0;
                            done_rco_cnt <= '0;
                        end else begin
                            state   <= RUN;
                            enable_ <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    cycles  <= cycles_nxt;
                    rco_cnt <= rco_cnt_nxt;
                    if (run_exit) begin
                        state        <= DONE;
                        enable_      <= 1'b0;
                        done_valid   <= 1'b1;
                        done_id      <= id_q;
                        done_cycles  <= cycles_nxt;
                        done_rco_cnt <= rco_cnt_nxt;
                    end
                end

                DONE: begin
                    done_valid <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    enable_    <= 1'b0;
                    done_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
